// File: rtl/spi_reg_arbiter.sv
// Round-robin arbiter sharing one SPI slave register port among NREQ requesters.
// Each access takes IDLE(grant) -> ACCESS(one cycle) -> DONE(Ack pulse).
//
// Ports:
//   Clk, Reset            clock, synchronous active-high reset
//   Req/Req_WE            per-requester request level and write select
//   Req_Addr/Req_Wdata    packed per-requester register index / write data
//   Ack                   one-hot completion pulse in the DONE cycle
//   Rdata                 read data of the last completed read
//   Busy                  high whenever the FSM is not IDLE
//   Data_WE/Data_Addr/Data_Write/Data_Read  SPI slave register port
module spi_reg_arbiter #(
  parameter int NREQ = 3
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [NREQ-1:0]      Req,
  input  logic [NREQ-1:0]      Req_WE,
  input  logic [4*NREQ-1:0]    Req_Addr,
  input  logic [32*NREQ-1:0]   Req_Wdata,
  output logic [NREQ-1:0]      Ack,
  output logic [31:0]          Rdata,
  output logic                 Busy,
  output logic                 Data_WE,
  output logic [3:0]           Data_Addr,
  output logic [31:0]          Data_Write,
  input  logic [31:0]          Data_Read
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e          state_q, state_d;
  // gnt_q is both the last winner (round-robin pointer)
  // and the index of the transaction in flight.
  logic [IW-1:0]   gnt_q, gnt_d;
  logic            we_q, we_d;
  logic [3:0]      addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [31:0]     rdata_q, rdata_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic            win_we;
  logic [3:0]      win_addr;
  logic [31:0]     win_wdata;

  // Round-robin scan starting one past the last winner.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = gnt_q;
    for (int k = 0; k < NREQ; k++) begin
      cand = (cand == IW'(NREQ - 1)) ? '0 : cand + 1'b1;
      if (!win_found && Req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Operand mux for the winner.
  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IW'(i)) begin
        win_we    = Req_WE[i];
        win_addr  = Req_Addr[4*i +: 4];
        win_wdata = Req_Wdata[32*i +: 32];
      end
    end
  end

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = win_found ? ACCESS : IDLE;
      ACCESS:  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    Busy = (state_q != IDLE);
    Ack  = '0;
    if (state_q == DONE) Ack[gnt_q] = 1'b1;
    Data_WE    = we_q;
    Data_Addr  = addr_q;
    Data_Write = wdata_q;
    Rdata      = rdata_q;
  end

  // Datapath next values
  always_comb begin
    gnt_d   = gnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (win_found) begin
          gnt_d   = win_idx;
          we_d    = win_we;
          addr_d  = win_addr;
          wdata_d = win_wdata;
        end
      end
      ACCESS: begin
        if (!we_q) rdata_d = Data_Read;
        we_d = 1'b0;
      end
      default: we_d = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      gnt_q   <= IW'(NREQ - 1);
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: tb/tb_spi_reg_arbiter.sv
// Self-checking bench for spi_reg_arbiter.
// Expected Ack/Rdata pairs are queued at stimulus time, popped on each Ack.
module tb_spi_reg_arbiter;

  localparam int NREQ = 3;

  logic          Clk = 1'b0;
  logic          Reset;
  logic [2:0]    Req;
  logic [2:0]    Req_WE;
  logic [11:0]   Req_Addr;
  logic [95:0]   Req_Wdata;
  logic [2:0]    Ack;
  logic [31:0]   Rdata;
  logic          Busy;
  logic          Data_WE;
  logic [3:0]    Data_Addr;
  logic [31:0]   Data_Write;
  logic [31:0]   Data_Read;

  spi_reg_arbiter #(.NREQ(NREQ)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Req        (Req),
    .Req_WE     (Req_WE),
    .Req_Addr   (Req_Addr),
    .Req_Wdata  (Req_Wdata),
    .Ack        (Ack),
    .Rdata      (Rdata),
    .Busy       (Busy),
    .Data_WE    (Data_WE),
    .Data_Addr  (Data_Addr),
    .Data_Write (Data_Write),
    .Data_Read  (Data_Read)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] rd_model(input logic [3:0] a);
    if (a == 4'd5) return 32'hDEAD_BEEF;
    return 32'hC0DE_0000 | {28'd0, a};
  endfunction

  assign Data_Read = rd_model(Data_Addr);

  typedef struct packed {
    logic [2:0]  ack;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  task automatic cycle();
    @(posedge Clk);
    #1;
  endtask

  task automatic push(input logic [2:0] a, input logic [31:0] r);
    exp_t e;
    e.ack   = a;
    e.rdata = r;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    Req   = '0;
    cycle();
    cycle();
    Reset = 1'b0;
  endtask

  // Drive mask; each requester drops on the edge sampling its Ack.
  // With rereq set, it raises again one cycle later.
  task automatic run_reqs(input logic [2:0] mask,
                          input int nacks,
                          input bit rereq);
    int seen = 0;
    int cyc = 0;
    logic [2:0] acked;
    Req = mask;
    while (seen < nacks && cyc < 100) begin
      acked = Ack;
      if (acked != '0) seen++;
      cycle();
      cyc++;
      if (seen >= nacks) Req = '0;
      else if (rereq)    Req = mask & ~acked;
      else               Req = Req & ~acked;
    end
    Req = '0;
    chk("acks_seen", 32'(seen), 32'(nacks));
  endtask

  // Scoreboard monitor plus protocol assertions
  always @(negedge Clk) begin
    assert ($onehot0(Ack)) else $error("Ack not one-hot");
    assert (!Data_WE || (Busy && Ack == '0))
      else $error("Data_WE outside ACCESS");
    assert (Busy || Ack == '0) else $error("Ack while idle");
    if (!Reset && Ack != '0) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {29'd0, Ack}, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_ack", {29'd0, Ack}, {29'd0, mon_e.ack});
        chk("sb_rdata", Rdata, mon_e.rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset     = 1'b1;
    Req       = '0;
    Req_WE    = '0;
    Req_Addr  = '0;
    Req_Wdata = '0;
    do_reset();
    cycle();
    chk("rst_ack",   {29'd0, Ack}, 32'd0);
    chk("rst_rdata", Rdata, 32'd0);
    chk("rst_busy",  {31'd0, Busy}, 32'd0);
    chk("rst_we",    {31'd0, Data_WE}, 32'd0);
    chk("rst_addr",  {28'd0, Data_Addr}, 32'd0);
    chk("rst_wdata", Data_Write, 32'd0);

    // Single read from requester 0
    Req_Addr[3:0] = 4'd5;
    push(3'b001, 32'hDEAD_BEEF);
    Req = 3'b001;
    cycle();
    chk("rd_addr", {28'd0, Data_Addr}, 32'd5);
    chk("rd_we",   {31'd0, Data_WE}, 32'd0);
    chk("rd_busy", {31'd0, Busy}, 32'd1);
    chk("rd_ack_t1", {29'd0, Ack}, 32'd0);
    cycle();
    chk("rd_ack_t2", {29'd0, Ack}, 32'd1);
    chk("rd_rdata",  Rdata, 32'hDEAD_BEEF);
    cycle();
    Req = '0;
    chk("rd_idle_busy", {31'd0, Busy}, 32'd0);

    // Single write from requester 1
    Req_WE[1]          = 1'b1;
    Req_Addr[7:4]      = 4'd3;
    Req_Wdata[63:32]   = 32'h1234_5678;
    push(3'b010, 32'hDEAD_BEEF);
    Req = 3'b010;
    cycle();
    chk("wr_we",    {31'd0, Data_WE}, 32'd1);
    chk("wr_addr",  {28'd0, Data_Addr}, 32'd3);
    chk("wr_wdata", Data_Write, 32'h1234_5678);
    cycle();
    chk("wr_we_done",   {31'd0, Data_WE}, 32'd0);
    chk("wr_ack",       {29'd0, Ack}, 32'd2);
    chk("wr_addr_hold", {28'd0, Data_Addr}, 32'd3);
    chk("wr_data_hold", Data_Write, 32'h1234_5678);
    cycle();
    Req    = '0;
    Req_WE = '0;

    // Contention: two full rounds from a fresh pointer
    do_reset();
    Req_Addr = {4'd7, 4'd2, 4'd1};
    for (int r = 0; r < 2; r++) begin
      push(3'b001, rd_model(4'd1));
      push(3'b010, rd_model(4'd2));
      push(3'b100, rd_model(4'd7));
      run_reqs(3'b111, 3, 1'b0);
      cycle();
    end

    // Fairness between requesters 0 and 2
    for (int k = 0; k < 5; k++) begin
      push(3'b001, rd_model(4'd1));
      push(3'b100, rd_model(4'd7));
    end
    run_reqs(3'b101, 10, 1'b1);
    cycle();
    cycle();

    // Reset in the ACCESS cycle of a write
    Req_WE[0]        = 1'b1;
    Req_Addr[3:0]    = 4'd9;
    Req_Wdata[31:0]  = 32'hAAAA_5555;
    Req = 3'b001;
    cycle();
    chk("mid_we_pre", {31'd0, Data_WE}, 32'd1);
    Reset = 1'b1;
    Req   = '0;
    cycle();
    Reset = 1'b0;
    chk("mid_we",   {31'd0, Data_WE}, 32'd0);
    chk("mid_ack",  {29'd0, Ack}, 32'd0);
    chk("mid_busy", {31'd0, Busy}, 32'd0);
    cycle();
    chk("mid_ack_late", {29'd0, Ack}, 32'd0);

    // Requester 0 completes normally afterwards
    Req_WE        = '0;
    Req_Addr[3:0] = 4'd5;
    push(3'b001, 32'hDEAD_BEEF);
    Req = 3'b001;
    cycle();
    chk("post_addr", {28'd0, Data_Addr}, 32'd5);
    cycle();
    chk("post_ack", {29'd0, Ack}, 32'd1);
    cycle();
    Req = '0;

    repeat (3) cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
